// File: rtl/lockbox_pkg.sv
// Shared types and default widths for the sweep peak finder.
package lockbox_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 14;
  localparam int DEFAULT_TIMEOUT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/peak_tracker.sv
// Running signed maximum of adc_in with the ramp code where it occurred.
// Ties keep the earliest sample; clear beats seed, seed beats update.
module peak_tracker
  import lockbox_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  seed,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] ramp_value,
  input  logic [DATA_WIDTH-1:0] adc_in,
  output logic [DATA_WIDTH-1:0] cand_ramp,
  output logic [DATA_WIDTH-1:0] cand_value
);

  logic better;

  // Strictly greater, so an equal later sample never displaces the first one.
  assign better = $signed(adc_in) > $signed(cand_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_ramp  <= '0;
      cand_value <= '0;
    end else if (clear) begin
      cand_ramp  <= '0;
      cand_value <= '0;
    end else if (seed || (update && better)) begin
      cand_ramp  <= ramp_value;
      cand_value <= adc_in;
    end
  end

endmodule

// File: rtl/sweep_peak_finder.sv
// Finds the transmission peak of each ramp sweep window bounded by ramp_start.
// Optional threshold acceptance is built when PEAK_THRESHOLD_EN is defined.
module sweep_peak_finder
  import lockbox_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     continuous,
  input  logic [DATA_WIDTH-1:0]    ramp_value,
  input  logic                     ramp_start,
  input  logic [DATA_WIDTH-1:0]    adc_in,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic [DATA_WIDTH-1:0]    threshold,
  output logic [DATA_WIDTH-1:0]    peak_ramp,
  output logic [DATA_WIDTH-1:0]    peak_value,
  output logic                     peak_valid,
  output logic                     peak_miss,
  output logic                     timeout,
  output logic                     busy
);

  state_t                   state_reg, state_next;
  logic [TIMEOUT_WIDTH-1:0] count_reg, count_next, count_inc;
  logic                     seed, update, clear;
  logic                     accept, timeout_hit;
  logic                     valid_next, miss_next, timeout_next;
  logic [DATA_WIDTH-1:0]    cand_ramp, cand_value;

  peak_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .seed       (seed),
    .update     (update),
    .ramp_value (ramp_value),
    .adc_in     (adc_in),
    .cand_ramp  (cand_ramp),
    .cand_value (cand_value)
  );

  assign count_inc   = (&count_reg) ? count_reg
                                    : count_reg + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  assign timeout_hit = (timeout_limit != '0) && (count_inc == timeout_limit);
  assign busy        = (state_reg == ARMED) || (state_reg == SCAN);

`ifdef PEAK_THRESHOLD_EN
  assign accept = $signed(cand_value) >= $signed(threshold);
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign accept           = 1'b1;
`endif

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    seed         = 1'b0;
    update       = 1'b0;
    clear        = 1'b0;
    valid_next   = 1'b0;
    miss_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
          count_next = '0;
        end else if (ramp_start) begin
          state_next = SCAN;
          seed       = 1'b1;
          count_next = '0;
        end else if (timeout_hit) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          clear        = 1'b1;
          count_next   = '0;
        end else begin
          count_next = count_inc;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
          clear      = 1'b1;
          count_next = '0;
        end else if (ramp_start) begin
          // Window close outranks a coinciding timeout; closing sample seeds the next window.
          count_next = '0;
          valid_next = accept;
          miss_next  = !accept;
          if (continuous) seed = 1'b1;
          else            state_next = DONE;
        end else if (timeout_hit) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          clear        = 1'b1;
          count_next   = '0;
        end else begin
          update     = 1'b1;
          count_next = count_inc;
        end
      end
      DONE: begin
        count_next = '0;
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      peak_ramp  <= '0;
      peak_value <= '0;
      peak_valid <= 1'b0;
      peak_miss  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      count_reg  <= count_next;
      peak_valid <= valid_next;
      peak_miss  <= miss_next;
      timeout    <= timeout_next;
      if (valid_next) begin
        peak_ramp  <= cand_ramp;
        peak_value <= cand_value;
      end
    end
  end

endmodule

// File: tb/tb_sweep_peak_finder.sv
// Directed bench for sweep_peak_finder: per-cycle vector table plus timeout,
// async reset and (with PEAK_THRESHOLD_EN) threshold sequences.
module tb_sweep_peak_finder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               continuous = 1'b0;
  logic signed [13:0] ramp_value = '0;
  logic               ramp_start = 1'b0;
  logic signed [13:0] adc_in = '0;
  logic [31:0]        timeout_limit = '0;
  logic signed [13:0] threshold = -14'sd8192;
  logic signed [13:0] peak_ramp;
  logic signed [13:0] peak_value;
  logic               peak_valid;
  logic               peak_miss;
  logic               timeout;
  logic               busy;

  int tests = 0;
  int failed = 0;

  sweep_peak_finder #(.DATA_WIDTH(14), .TIMEOUT_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .continuous    (continuous),
    .ramp_value    (ramp_value),
    .ramp_start    (ramp_start),
    .adc_in        (adc_in),
    .timeout_limit (timeout_limit),
    .threshold     (threshold),
    .peak_ramp     (peak_ramp),
    .peak_value    (peak_value),
    .peak_valid    (peak_valid),
    .peak_miss     (peak_miss),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, cont, rs;
    int   ramp, adc, lim;
    logic busy, valid, to;
    int   pr, pv;
  } vec_t;

  localparam int NV = 39;
  vec_t vecs[NV];

  function automatic vec_t v(input logic en, input logic cont, input logic rs,
                             input int ramp, input int adc, input int lim,
                             input logic b, input logic vl, input logic to,
                             input int pr, input int pv);
    vec_t r;
    r.en = en; r.cont = cont; r.rs = rs; r.ramp = ramp; r.adc = adc; r.lim = lim;
    r.busy = b; r.valid = vl; r.to = to; r.pr = pr; r.pv = pv;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Drive one cycle's inputs, let the edge pass, then sample 1ns later.
  task automatic cycle(input logic e, input logic c, input logic r, input int rv, input int av);
    enable     = e;
    continuous = c;
    ramp_start = r;
    ramp_value = 14'(rv);
    adc_in     = 14'(av);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_at;
    int busy_at_100;
    logic ok;

    //              en cont rs  ramp   adc lim  busy val to   pr    pv
    vecs[0]  = v(0, 0, 1,     5,   99, 0,  0, 0, 0,     0,    0);
    vecs[1]  = v(1, 0, 0,     0,    0, 0,  1, 0, 0,     0,    0);
    vecs[2]  = v(1, 0, 1,   100,   10, 0,  1, 0, 0,     0,    0);
    vecs[3]  = v(1, 0, 0,  1200, 5000, 0,  1, 0, 0,     0,    0);
    vecs[4]  = v(1, 0, 0,  1300, 4000, 0,  1, 0, 0,     0,    0);
    vecs[5]  = v(1, 0, 1,     0, 6000, 0,  0, 1, 0,  1200, 5000);
    vecs[6]  = v(1, 0, 0,     0,    0, 0,  0, 0, 0,  1200, 5000);
    vecs[7]  = v(0, 0, 0,     0,    0, 0,  0, 0, 0,  1200, 5000);
    vecs[8]  = v(1, 0, 0,     0,    0, 0,  1, 0, 0,  1200, 5000);
    vecs[9]  = v(1, 0, 1, -1000,  -50, 0,  1, 0, 0,  1200, 5000);
    vecs[10] = v(1, 0, 0,  -400, 3000, 0,  1, 0, 0,  1200, 5000);
    vecs[11] = v(1, 0, 0,   800, 3000, 0,  1, 0, 0,  1200, 5000);
    vecs[12] = v(1, 0, 0,   900, 2999, 0,  1, 0, 0,  1200, 5000);
    vecs[13] = v(1, 0, 1,     0,    0, 0,  0, 1, 0,  -400, 3000);
    vecs[14] = v(0, 0, 0,     0,    0, 0,  0, 0, 0,  -400, 3000);
    vecs[15] = v(1, 1, 0,     0,    0, 0,  1, 0, 0,  -400, 3000);
    vecs[16] = v(1, 1, 1,     0,  100, 0,  1, 0, 0,  -400, 3000);
    vecs[17] = v(1, 1, 0,    10,  700, 0,  1, 0, 0,  -400, 3000);
    vecs[18] = v(1, 1, 1,    20,  900, 0,  1, 1, 0,    10,  700);
    vecs[19] = v(1, 1, 0,    30,  500, 0,  1, 0, 0,    10,  700);
    vecs[20] = v(1, 1, 1,    40,   -5, 0,  1, 1, 0,    20,  900);
    vecs[21] = v(1, 1, 0,    50, -100, 0,  1, 0, 0,    20,  900);
    vecs[22] = v(1, 1, 0,    60,   -3, 0,  1, 0, 0,    20,  900);
    vecs[23] = v(1, 0, 1,    70,    0, 0,  0, 1, 0,    60,   -3);
    vecs[24] = v(0, 0, 0,     0,    0, 0,  0, 0, 0,    60,   -3);
    vecs[25] = v(1, 1, 0,     0,    0, 0,  1, 0, 0,    60,   -3);
    vecs[26] = v(1, 1, 1,     5, 2000, 0,  1, 0, 0,    60,   -3);
    vecs[27] = v(1, 1, 0,     6, 2500, 0,  1, 0, 0,    60,   -3);
    vecs[28] = v(0, 1, 0,     7,    0, 0,  0, 0, 0,    60,   -3);
    vecs[29] = v(0, 1, 1,     8,    0, 0,  0, 0, 0,    60,   -3);
    vecs[30] = v(1, 1, 0,     0,    0, 3,  1, 0, 0,    60,   -3);
    vecs[31] = v(1, 1, 1,     1,   11, 3,  1, 0, 0,    60,   -3);
    vecs[32] = v(1, 1, 0,     2,   22, 3,  1, 0, 0,    60,   -3);
    vecs[33] = v(1, 1, 0,     3,   33, 3,  1, 0, 0,    60,   -3);
    vecs[34] = v(1, 1, 1,     4,   44, 3,  1, 1, 0,     3,   33);
    vecs[35] = v(1, 1, 0,     5,    1, 3,  1, 0, 0,     3,   33);
    vecs[36] = v(1, 1, 0,     6,    2, 3,  1, 0, 0,     3,   33);
    vecs[37] = v(1, 1, 0,     7,    3, 3,  0, 0, 1,     3,   33);
    vecs[38] = v(0, 1, 0,     0,    0, 3,  0, 0, 0,     3,   33);

    // Reset state, checked while rst is still high.
    #12;
    check("reset_busy",  int'(busy), 0);
    check("reset_valid", int'(peak_valid), 0);
    check("reset_peak_ramp", int'(peak_ramp), 0);
    check("reset_peak_value", int'(peak_value), 0);
    check("reset_miss_timeout", int'({peak_miss, timeout}), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      timeout_limit = 32'(vecs[i].lim);
      cycle(vecs[i].en, vecs[i].cont, vecs[i].rs, vecs[i].ramp, vecs[i].adc);
      ok = (busy === vecs[i].busy) && (peak_valid === vecs[i].valid) &&
           (timeout === vecs[i].to) && (peak_miss === 1'b0) &&
           (int'(peak_ramp) == vecs[i].pr) && (int'(peak_value) == vecs[i].pv);
      tests++;
      if (!ok) begin
        failed++;
        $display("FAIL row%0d: got busy=%0b valid=%0b to=%0b miss=%0b peak=%0d/%0d, want busy=%0b valid=%0b to=%0b miss=0 peak=%0d/%0d",
                 i, busy, peak_valid, timeout, peak_miss, peak_ramp, peak_value,
                 vecs[i].busy, vecs[i].valid, vecs[i].to, vecs[i].pr, vecs[i].pv);
      end else begin
        $display("[TB] row %0d ok busy=%0b valid=%0b to=%0b peak=%0d/%0d",
                 i, busy, peak_valid, timeout, peak_ramp, peak_value);
      end
    end

    // Timeout of 100 with no ramp_start: pulse after the 100th ARMED cycle.
    timeout_limit = 32'd100;
    seen_at = 0;
    busy_at_100 = 0;
    for (int n = 1; n <= 150; n++) begin
      cycle(1'b1, 1'b0, 1'b0, n, 0);
      if (n == 100) busy_at_100 = int'(busy);
      if (timeout) begin
        seen_at = n;
        break;
      end
    end
    check("timeout_edge_index", seen_at, 101);
    check("busy_before_timeout", busy_at_100, 1);
    check("busy_at_timeout", int'(busy), 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    check("timeout_one_cycle", int'(timeout), 0);
    timeout_limit = '0;

`ifdef PEAK_THRESHOLD_EN
    threshold = 14'sd2000;
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1, 1, 100);
    cycle(1'b1, 1'b0, 1'b0, 2, 1500);
    cycle(1'b1, 1'b0, 1'b1, 3, 0);
    check("thr_miss_pulse", int'({peak_valid, peak_miss}), 1);
    check("thr_miss_keeps_ramp", int'(peak_ramp), 3);
    check("thr_miss_keeps_value", int'(peak_value), 33);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    threshold = 14'sd1000;
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1, 1, 100);
    cycle(1'b1, 1'b0, 1'b0, 2, 1500);
    cycle(1'b1, 1'b0, 1'b1, 3, 0);
    check("thr_accept_pulse", int'({peak_valid, peak_miss}), 2);
    check("thr_accept_ramp", int'(peak_ramp), 2);
    check("thr_accept_value", int'(peak_value), 1500);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    threshold = -14'sd8192;
`endif

    // Async reset while a valid pulse is high and the finder is scanning.
    cycle(1'b1, 1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 1'b1, 77, 777);
    cycle(1'b1, 1'b1, 1'b1, 78, 10);
    check("pre_reset_valid", int'({busy, peak_valid}), 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(peak_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_peak", int'({peak_ramp, peak_value}), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 0, 500);
    cycle(1'b1, 1'b0, 1'b0, 1, 600);
    check("post_reset_needs_start", int'({busy, peak_valid}), 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sweep_peak_finder.md
SWEEP_PEAK_FINDER -- requirements
Module: sweep_peak_finder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: width of ramp and ADC samples, signed two's complement.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 32: width of the sweep-timeout counter and limit.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1: arms the finder while high.
REQ-006 SHALL have port continuous, input, 1: 1 = re-arm after every sweep; 0 = single shot.
REQ-007 SHALL have port ramp_value, input, DATA_WIDTH: current ramp DAC code, from the ramp generator.
REQ-008 SHALL have port ramp_start, input, 1: one-cycle pulse marking the sweep boundary at the ramp top.
REQ-009 SHALL have port adc_in, input, DATA_WIDTH: transmission sample aligned with ramp_value.
REQ-010 SHALL have port timeout_limit, input, TIMEOUT_WIDTH: maximum cycles between ramp_start pulses; 0 disables the timeout.
REQ-011 SHALL have port threshold, input, DATA_WIDTH: minimum accepted peak; used only with PEAK_THRESHOLD_EN.
REQ-012 SHALL have port peak_ramp, output, DATA_WIDTH: ramp_value at the last reported peak.
REQ-013 SHALL have port peak_value, output, DATA_WIDTH: adc_in at the last reported peak.
REQ-014 SHALL have port peak_valid, output, 1: one-cycle pulse when peak_ramp and peak_value update.
REQ-015 SHALL have port peak_miss, output, 1: one-cycle pulse when a sweep completes without an accepted peak.
REQ-016 SHALL have port timeout, output, 1: one-cycle pulse on sweep timeout.
REQ-017 SHALL have port busy, output, 1: high in ARMED and SCAN.

Function
REQ-018 SHALL implement the FSM states IDLE, ARMED, SCAN and DONE.
REQ-019 IDLE SHALL go to ARMED when enable=1.
REQ-020 ARMED SHALL go to SCAN on ramp_start; that cycle's sample SHALL load the tracker as the first candidate.
REQ-021 In SCAN, each cycle SHALL replace the candidate only if signed adc_in > candidate; ties keep the earliest sample.
REQ-022 In SCAN, ramp_start SHALL close the window; the closing-cycle sample SHALL be excluded and SHALL seed the next window if it re-arms.
REQ-023 After a window closes, peak outputs SHALL update and peak_valid SHALL pulse exactly one cycle later (latency 1).
REQ-024 After a window closes, the FSM SHALL stay in SCAN with a re-seeded tracker if continuous=1, and SHALL go to DONE if continuous=0.
REQ-025 DONE SHALL hold outputs and SHALL return to IDLE when enable=0.
REQ-026 The timeout counter SHALL clear on every ramp_start, count in ARMED and SCAN, and saturate at all ones.
REQ-027 When the counter equals a nonzero timeout_limit, the block SHALL pulse timeout, discard the candidate, and go to IDLE.
REQ-028 When enable=0 in ARMED or SCAN, the block SHALL abort to IDLE next cycle with no peak_valid or peak_miss; peak outputs SHALL keep their previous values.
REQ-029 If a window close and the timeout fall in the same cycle, the window close SHALL take precedence and the counter SHALL clear.
REQ-030 peak_valid, peak_miss and timeout SHALL be mutually exclusive in every cycle.

Reset
REQ-031 Reset SHALL asynchronously force state IDLE, counter 0, candidate 0, and every output (peak_ramp, peak_value, peak_valid, peak_miss, timeout, busy) to 0.
REQ-032 After reset deasserts, the block SHALL need enable plus a fresh ramp_start before it reports anything.

Configuration
REQ-033 The macro PEAK_THRESHOLD_EN SHALL control peak acceptance.
- Defined: a closed window SHALL report peak_valid only if the signed candidate >= threshold; otherwise it SHALL pulse peak_miss and leave the peak outputs unchanged.
- Undefined: every closed window SHALL report peak_valid; peak_miss SHALL be tied to 0; threshold SHALL be ignored.

Structure
REQ-034 Shared package lockbox_pkg SHALL hold the FSM state enum and the default DATA_WIDTH and TIMEOUT_WIDTH constants.
REQ-035 The compare-and-hold logic SHALL be one sub-module, peak_tracker: seed/update inputs, candidate value and ramp outputs.

Verification
REQ-036 enable=1, continuous=0, adc peaks at 5000 when ramp=1200 in a window between two ramp_start pulses -> one peak_valid one cycle after the second ramp_start, peak_ramp=1200, peak_value=5000, then DONE.
REQ-037 Two equal maxima of 3000 at ramp=-400 then ramp=800 -> peak_ramp=-400.
REQ-038 continuous=1, three consecutive windows -> exactly three peak_valid pulses, each matching its own window's maximum; the closing sample seeds the next window.
REQ-039 timeout_limit=100, no ramp_start after arming -> timeout pulse on the 100th counted cycle, back in IDLE, busy=0.
REQ-040 PEAK_THRESHOLD_EN defined, threshold=2000, window maximum 1500 -> peak_miss pulse and prior peak outputs unchanged; with threshold=1000 -> peak_valid.
REQ-041 enable dropped mid-SCAN, or rst asserted mid-SCAN -> no valid/miss pulse; rst zeroes all outputs immediately, without waiting for a clock edge.
